// File: rtl/data_bus_master.sv
// data_bus_master: initiator side of the data bus.
// Turns the memory stage's level read/write request into a single bus
// transfer, honours the responder's Waitreq, captures read data after a
// fixed latency, stalls the pipeline until done, and flags timeouts and
// illegal (read+write) requests in a sticky error bit.
module data_bus_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] MemAddr,
  input  logic [15:0] MemWData,
  output logic [15:0] MemRData,
  output logic        MemStall,
  output logic        MemDone,
  output logic        BusErr,
  output logic        ReadData,
  output logic        WriteData,
  output logic [15:0] DataAddr,
  output logic [15:0] BusIn,
  input  logic [15:0] BusOut,
  input  logic        Waitreq
);

  localparam int DATA_W = 16;

  // Wait counter is at least 4 bits, wider only if the timeout needs it.
  localparam int WCW = (TIMEOUT_CYCLES > 15) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  localparam logic [WCW:0] TIMEOUT_W    = TIMEOUT_CYCLES[WCW:0];
  localparam logic [2:0]   READ_LAT_W   = READ_LATENCY[2:0];
  localparam logic [DATA_W-1:0] ABORT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dir_q, dir_d;      // 1 = write
  logic [2:0]        lat_q, lat_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [WCW:0]      wait_inc;

  // Saturating increment so a long stall can never wrap back to zero.
  function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
    if (v == {WCW{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Wait count including the current Waitreq cycle, one bit wider so the
  // comparison against the timeout never overflows.
  assign wait_inc = {1'b0, wait_q} + 1'b1;

  // Next-state and register-update logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dir_d   = dir_q;
    lat_d   = lat_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = MemAddr;
          wdata_d = MemWData;
          dir_d   = MemWrite;
          wait_d  = '0;
          state_d = S_ISSUE;
          // Both requests at once is illegal; it proceeds as a write.
          if (MemRead && MemWrite) begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!Waitreq) begin
          if (dir_q) begin
            state_d = S_DONE;
          end else if (READ_LATENCY == 0) begin
            rdata_d = BusOut;
            state_d = S_DONE;
          end else begin
            lat_d   = READ_LAT_W;
            state_d = S_RDWAIT;
          end
        end else begin
          wait_d = sat_inc(wait_q);
          if ((TIMEOUT_CYCLES != 0) && (wait_inc >= TIMEOUT_W)) begin
            rdata_d = ABORT_DATA;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RDWAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q <= 3'd1) begin
          rdata_d = BusOut;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Requests still visible here belong to the finished instruction.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: strobes only in ISSUE, bus address/data zero when idle.
  always_comb begin
    ReadData  = 1'b0;
    WriteData = 1'b0;
    DataAddr  = '0;
    BusIn     = '0;
    MemStall  = 1'b0;
    MemDone   = 1'b0;
    case (state_q)
      S_IDLE: begin
        MemStall = MemRead | MemWrite;
      end
      S_ISSUE: begin
        ReadData  = ~dir_q;
        WriteData = dir_q;
        DataAddr  = addr_q;
        BusIn     = wdata_q;
        MemStall  = 1'b1;
      end
      S_RDWAIT: begin
        DataAddr = addr_q;
        MemStall = 1'b1;
      end
      S_DONE: begin
        MemDone = 1'b1;
      end
      default: begin
        MemStall = 1'b0;
      end
    endcase
  end

  assign MemRData = rdata_q;
  assign BusErr   = err_q;

  // Control state: FSM, counters, captured read result and sticky error.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Latched request fields; only observed outside IDLE, so no reset needed.
  always_ff @(posedge Clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    dir_q   <= dir_d;
  end

endmodule

// File: tb/tb_data_bus_master.sv
// Scoreboard bench for data_bus_master (READ_LATENCY=1, TIMEOUT_CYCLES=4).
// Stimulus pushes the expected completion into a queue; a negedge monitor
// checks every strobe cycle and every MemDone against the queue head.
module tb_data_bus_master;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        MemRead, MemWrite;
  logic [15:0] MemAddr, MemWData;
  logic [15:0] MemRData;
  logic        MemStall, MemDone, BusErr;
  logic        ReadData, WriteData;
  logic [15:0] DataAddr, BusIn;
  logic [15:0] BusOut;
  logic        Waitreq;

  always #5 Clock = ~Clock;

  data_bus_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemStall(MemStall), .MemDone(MemDone),
    .BusErr(BusErr), .ReadData(ReadData), .WriteData(WriteData),
    .DataAddr(DataAddr), .BusIn(BusIn), .BusOut(BusOut), .Waitreq(Waitreq)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        wr;
    logic        err;
    int          strobes;
    int          lat;
    int          start;
  } exp_t;

  exp_t sbq[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int strb_cnt  = 0;
  int stall_cnt = 0;
  int orphan    = 0;

  // Responder model
  int          wait_total = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;
  logic [15:0] resp_data = 16'h0000;

  assign Waitreq = (ReadData | WriteData) && (stuck || (wcnt < wait_total));

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    wcnt <= (ReadData | WriteData) ? wcnt + 1 : 0;
    BusOut <= (ReadData && !Waitreq) ? resp_data : 16'h0BAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: per-strobe-cycle bus checks and per-completion scoreboard pop.
  always @(negedge Clock) begin
    if (ReadData || WriteData) begin
      if (sbq.size() == 0) begin
        orphan++;
      end else begin
        strb_cnt++;
        chk("bus_addr", {16'h0, DataAddr}, {16'h0, sbq[0].addr});
        chk("bus_dir", {31'h0, WriteData}, {31'h0, sbq[0].wr});
        chk("one_strobe", {31'h0, ReadData & WriteData}, 32'h0);
        if (WriteData) chk("bus_wdata", {16'h0, BusIn}, {16'h0, sbq[0].wdata});
      end
    end
    if (sbq.size() != 0 && MemStall) stall_cnt++;
    if (MemDone) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        automatic exp_t e = sbq.pop_front();
        chk("rdata", {16'h0, MemRData}, {16'h0, e.rdata});
        chk("buserr", {31'h0, BusErr}, {31'h0, e.err});
        chk("strobe_cycles", strb_cnt, e.strobes);
        chk("stall_cycles", stall_cnt, e.lat);
        chk("done_latency", cyc - e.start, e.lat);
        chk("done_quiet", {29'h0, ReadData, WriteData, MemStall}, 32'h0);
      end
      strb_cnt  = 0;
      stall_cnt = 0;
    end
  end

  // Issue one request, hold it until MemDone has been seen, then release.
  task automatic do_xfer(input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] resp, input int nwait,
                         input logic stk, input logic scr,
                         input logic [15:0] exp_rdata, input logic exp_err,
                         input int exp_strb, input int exp_lat);
    exp_t e;
    logic seen;
    e.addr = addr; e.wdata = wdata; e.rdata = exp_rdata; e.wr = wr;
    e.err = exp_err; e.strobes = exp_strb; e.lat = exp_lat; e.start = cyc;
    resp_data = resp; wait_total = nwait; stuck = stk;
    MemRead = rd; MemWrite = wr; MemAddr = addr; MemWData = wdata;
    sbq.push_back(e);
    @(posedge Clock); #1;
    if (scr) begin
      MemAddr  = 16'hFFFF;
      MemWData = 16'h0000;
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (MemDone) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'h0, 32'h1);
      sbq.delete();
    end
    @(posedge Clock); #1;
    MemRead = 1'b0; MemWrite = 1'b0; MemAddr = 16'h0; MemWData = 16'h0;
    stuck = 1'b0; wait_total = 0;
    @(posedge Clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    MemAddr = 16'h0; MemWData = 16'h0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_strobes", {30'h0, ReadData, WriteData}, 32'h0);
    chk("rst_addr", {16'h0, DataAddr}, 32'h0);
    chk("rst_busin", {16'h0, BusIn}, 32'h0);
    chk("rst_rdata", {16'h0, MemRData}, 32'h0);
    chk("rst_flags", {29'h0, MemDone, BusErr, MemStall}, 32'h0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Plain write: 1 strobe cycle, MemDone 2 cycles after request.
    do_xfer(1'b0, 1'b1, 16'h0012, 16'hBEEF, 16'h0, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 2);
    // Read, latency 1: data one cycle after accept, MemDone at cycle 3.
    do_xfer(1'b1, 1'b0, 16'h0040, 16'h0, 16'h1234, 0, 1'b0, 1'b0, 16'h1234, 1'b0, 1, 3);
    // Write held off 3 cycles with inputs scrambled during ISSUE.
    do_xfer(1'b0, 1'b1, 16'h1000, 16'h5A5A, 16'h0, 3, 1'b0, 1'b1, 16'h1234, 1'b0, 4, 5);
    // Stuck responder: abort after 4 wait cycles with FFFF and BusErr.
    do_xfer(1'b1, 1'b0, 16'hABCD, 16'h0, 16'h0, 0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 4, 5);
    // BusErr remains set across a later good transfer.
    do_xfer(1'b0, 1'b1, 16'h0002, 16'h1111, 16'h0, 0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1, 2);
    chk("err_sticky", {31'h0, BusErr}, 32'h1);

    // Reset in the middle of ISSUE: silent abort.
    orphan = 0;
    MemRead = 1'b1; MemAddr = 16'h0300; stuck = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b1; MemRead = 1'b0; MemAddr = 16'h0;
    @(negedge Clock);
    chk("issue_before_rst", {31'h0, ReadData}, 32'h1);
    @(posedge Clock); #1;
    Reset = 1'b0; stuck = 1'b0;
    @(negedge Clock);
    chk("rst_abort_strobes", {30'h0, ReadData, WriteData}, 32'h0);
    chk("rst_abort_addr", {16'h0, DataAddr}, 32'h0);
    chk("rst_abort_err", {31'h0, BusErr}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_abort_nodone", {31'h0, MemDone}, 32'h0);
      @(negedge Clock);
    end
    chk("rst_abort_orphans", orphan, 1);
    @(posedge Clock); #1;
    // A fresh read after reset completes normally.
    do_xfer(1'b1, 1'b0, 16'h0077, 16'h0, 16'hC0DE, 0, 1'b0, 1'b0, 16'hC0DE, 1'b0, 1, 3);

    // Read and write together: issued as a write, BusErr set, one transfer.
    orphan = 0;
    do_xfer(1'b1, 1'b1, 16'h0055, 16'h7777, 16'h0, 0, 1'b0, 1'b0, 16'hC0DE, 1'b1, 1, 2);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("both_single_xfer", orphan, 0);
    chk("both_err_sticky", {31'h0, BusErr}, 32'h1);
    chk("queue_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
